// File: rtl/write_port_arbiter.sv
// Line-granular round-robin scheduler sharing one pixel-pair write port between two
// filter pipelines; the port stays locked to its owner for a whole image line.
module write_port_arbiter #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [1:0]  en,
    input  logic        req0_valid,
    input  logic [47:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [47:0] req1_data,
    output logic        req1_ready,
    input  logic        wr_ready,
    output logic        out_valid,
    output logic [47:0] out_data,
    output logic        out_sel,
    output logic        out_last,
    output logic [15:0] out_line,
    output logic [1:0]  frame_done,
    output logic        all_done
);

    localparam int BEATS = WIDTH / 2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = $clog2(HEIGHT + 1);

    typedef enum logic [1:0] {IDLE, ARB, LINE, DONE} state_t;

    state_t          state, state_nxt;
    logic   [1:0]    done;
    logic   [BW-1:0] beat     [2];
    logic   [LW-1:0] line_cnt [2];
    logic            sel;
    logic            last_grant;

    logic            start_ok;
    logic   [1:0]    cand;
    logic            grant;
    logic            cur_valid;
    logic            xfer;
    logic            beat_last;
    logic   [LW-1:0] line_nxt;
    logic   [1:0]    done_upd;

    assign start_ok  = start && (state == IDLE || state == DONE);
    assign cand      = {req1_valid & ~done[1], req0_valid & ~done[0]};
    // Two candidates: the one that did not win last time; otherwise the sole candidate.
    assign grant     = (cand == 2'b11) ? ~last_grant : cand[1];
    assign cur_valid = sel ? req1_valid : req0_valid;
    assign xfer      = (state == LINE) && cur_valid && wr_ready;
    assign beat_last = (beat[sel] == BW'(BEATS - 1));
    assign line_nxt  = line_cnt[sel] + LW'(1);
    assign done_upd  = done | ((line_nxt == LW'(HEIGHT)) ? (2'b01 << sel) : 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start_ok) state_nxt = (en == 2'b00) ? DONE : ARB;
            ARB:        if (|cand) state_nxt = LINE;
            LINE:       if (xfer && beat_last) state_nxt = (&done_upd) ? DONE : ARB;
            default:    state_nxt = IDLE;
        endcase
    end

    // NOTE: the per-requester counters are a handful of flops, not a memory, so they
    // are reset with everything else to discard a partial line.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            done       <= 2'b00;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                beat[i]     <= '0;
                line_cnt[i] <= '0;
            end
        end else if (start_ok) begin
            done       <= ~en;
            last_grant <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                beat[i]     <= '0;
                line_cnt[i] <= '0;
            end
        end else if (state == ARB && |cand) begin
            sel        <= grant;
            last_grant <= grant;
        end else if (xfer) begin
            if (beat_last) begin
                beat[sel]     <= '0;
                line_cnt[sel] <= line_nxt;
                done          <= done_upd;
            end else begin
                beat[sel] <= beat[sel] + BW'(1);
            end
        end
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        if (state == LINE) begin
            req0_ready = ~sel & wr_ready;
            req1_ready = sel & wr_ready;
            out_valid  = cur_valid;
            out_data   = sel ? req1_data : req0_data;
            out_last   = beat_last;
        end
    end

    assign out_sel    = sel;
    assign out_line   = 16'(line_cnt[sel]);
    assign frame_done = done;
    assign all_done   = (state == DONE);

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed bench for write_port_arbiter at WIDTH=8, HEIGHT=2 with a beat scoreboard
// filled from a reference schedule and drained on every observed handshake.
module tb_write_port_arbiter;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 2;
    localparam int BEATS  = WIDTH / 2;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [1:0]  en;
    logic        req0_valid, req1_valid;
    logic [47:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wr_ready;
    logic        out_valid;
    logic [47:0] out_data;
    logic        out_sel;
    logic        out_last;
    logic [15:0] out_line;
    logic [1:0]  frame_done;
    logic        all_done;

    write_port_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .en(en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_ready(wr_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_last(out_last), .out_line(out_line),
        .frame_done(frame_done), .all_done(all_done)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        sel;
        logic [47:0] data;
        logic        last;
        logic [15:0] line;
    } beat_t;

    beat_t sb[$];
    int    passed = 0;
    int    total  = 0;
    int    seq [2];
    int    eseq[2];
    int    cyc = 0;
    int    t0;
    int    n;

    function automatic logic [47:0] pix(input int r, input int k);
        return {8'hA0 + 8'(r), 24'h5A5A5A, 16'(k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_line(input int r, input int ln);
        for (int b = 0; b < BEATS; b++) begin
            sb.push_back('{1'(r), pix(r, eseq[r]), (b == BEATS - 1), 16'(ln)});
            eseq[r]++;
        end
    endtask

    task automatic monitor();
        logic [1:0] rv, rr;
        beat_t      e;
        rv = {req1_valid, req0_valid};
        rr = {req1_ready, req0_ready};
        for (int r = 0; r < 2; r++) begin
            if (frame_done[r]) check($sformatf("ready_after_done%0d", r), 64'(rr[r]), 64'd0);
            if (rv[r] && rr[r]) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_beat_req%0d", r), 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_sel", 64'(out_sel), 64'(e.sel));
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_last", 64'(out_last), 64'(e.last));
                    check("out_line", 64'(out_line), 64'(e.line));
                    check("out_valid", 64'(out_valid), 64'd1);
                end
                seq[r]++;
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic tick();
        req0_data = pix(0, seq[0]);
        req1_data = pix(1, seq[1]);
        #1;
        monitor();
        @(negedge HCLK);
        cyc++;
    endtask

    task automatic do_start(input logic [1:0] e);
        seq  = '{0, 0};
        eseq = '{0, 0};
        start = 1'b1;
        en    = e;
        tick();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(output int cycles);
        int k = 0;
        while (!all_done && k < 200) begin
            tick();
            k++;
        end
        if (!all_done) check("done_timeout", 64'd0, 64'd1);
        cycles = cyc - t0;
    endtask

    task automatic wait_seq(input int r, input int target);
        int k = 0;
        while (seq[r] < target && k < 100) begin
            tick();
            k++;
        end
        if (seq[r] < target) check("seq_timeout", 64'(seq[r]), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn    = 1'b0;
        start      = 1'b0;
        en         = 2'b00;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        wr_ready   = 1'b1;
        seq        = '{0, 0};
        eseq       = '{0, 0};
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sel_last_line", 64'({out_sel, out_last, out_line}), 64'd0);
        check("rst_done", 64'({frame_done, all_done}), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();

        // Single requester; req1 valid but disabled must never be served.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        do_start(2'b01);
        check("s1_not_done", 64'({frame_done[0], all_done}), 64'd0);
        push_line(0, 0);
        push_line(0, 1);
        wait_done(n);
        check("s1_cycles", 64'(n), 64'(2 * (BEATS + 1)));
        check("s1_done0", 64'({frame_done[0], all_done}), 64'b11);
        check("s1_sb_empty", 64'(sb.size()), 64'd0);

        // Both streaming: alternate lines 0,1,0,1 with one bubble per line.
        do_start(2'b11);
        push_line(0, 0);
        push_line(1, 0);
        push_line(0, 1);
        push_line(1, 1);
        wait_done(n);
        check("s2_cycles", 64'(n), 64'(4 * (BEATS + 1)));
        check("s2_done", 64'({frame_done, all_done}), 64'b111);
        check("s2_sb_empty", 64'(sb.size()), 64'd0);

        // Writer stall mid-line: owner holds the port, nobody gets ready.
        do_start(2'b11);
        push_line(0, 0);
        push_line(1, 0);
        push_line(0, 1);
        push_line(1, 1);
        wait_seq(0, 2);
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 64'({req1_ready, req0_ready}), 64'd0);
            check("stall_owner", 64'({out_sel, out_valid}), 64'b01);
            tick();
        end
        wr_ready = 1'b1;
        wait_done(n);
        check("s3_cycles", 64'(n), 64'(4 * (BEATS + 1) + 3));
        check("s3_sb_empty", 64'(sb.size()), 64'd0);

        // Only req1 present at first arbitration, then round-robin hands over to req0.
        req0_valid = 1'b0;
        do_start(2'b11);
        push_line(1, 0);
        push_line(0, 0);
        push_line(1, 1);
        push_line(0, 1);
        wait_seq(1, 1);
        req0_valid = 1'b1;
        wait_done(n);
        check("s4_cycles", 64'(n), 64'(4 * (BEATS + 1)));
        check("s4_sb_empty", 64'(sb.size()), 64'd0);

        // start during LINE is ignored; schedule and timing stay intact.
        req1_valid = 1'b0;
        do_start(2'b01);
        push_line(0, 0);
        push_line(0, 1);
        wait_seq(0, 1);
        start = 1'b1;
        en    = 2'b11;
        tick();
        start = 1'b0;
        wait_done(n);
        check("s6_cycles", 64'(n), 64'(2 * (BEATS + 1)));
        check("s6_sb_empty", 64'(sb.size()), 64'd0);

        // Restart from DONE with only req1 enabled; req0 stays marked done.
        req1_valid = 1'b1;
        do_start(2'b10);
        check("s7_start_done", 64'({frame_done, all_done}), 64'b010);
        push_line(1, 0);
        push_line(1, 1);
        wait_seq(1, 4);
        check("s7_mid_done", 64'({frame_done, all_done}), 64'b010);
        wait_done(n);
        check("s7_cycles", 64'(n), 64'(2 * (BEATS + 1)));
        check("s7_final_done", 64'({frame_done, all_done}), 64'b111);
        check("s7_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a line, then a clean restart.
        req1_valid = 1'b0;
        do_start(2'b01);
        push_line(0, 0);
        wait_seq(0, 2);
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1;
        HRESETn = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_sel_last_line", 64'({out_sel, out_last, out_line}), 64'd0);
        check("arst_done", 64'({frame_done, all_done}), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        sb.delete();
        tick();
        do_start(2'b01);
        push_line(0, 0);
        push_line(0, 1);
        wait_done(n);
        check("s5_cycles", 64'(n), 64'(2 * (BEATS + 1)));
        check("s5_done", 64'({frame_done[0], all_done}), 64'b11);
        check("s5_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
